// File: rtl/fifo_byte_unpacker_pkg.sv
// Definitions shared by the byte unpacker slice: the FIFO word width and a clog2 helper
// used when sizing counters and pointers.
package fifo_byte_unpacker_pkg;

    localparam int FIFO_DATA_W = 32;

    function automatic int clog2(input int value);
        int result;
        int v;
        result = 0;
        v      = value - 1;
        while (v > 0) begin
            result++;
            v = v >> 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/fifo_byte_unpacker_if.sv
// Bundles the FIFO first-word-fall-through read port and the byte-stream output handshake.
// The unpacker uses the master view; the FIFO/sink side uses the slave view.
interface fifo_byte_unpacker_if
    import fifo_byte_unpacker_pkg::*;
#(
    parameter int DATA_W = FIFO_DATA_W,
    parameter int OUT_W  = 8
);
    logic              fifoEmpty;
    logic [DATA_W-1:0] fifoData;
    logic              fifoREn;
    logic              mValid;
    logic              mReady;
    logic [OUT_W-1:0]  mData;
    logic              mFirst;
    logic              mLast;

    modport master (
        input  fifoEmpty, fifoData, mReady,
        output fifoREn, mValid, mData, mFirst, mLast
    );

    modport slave (
        output fifoEmpty, fifoData, mReady,
        input  fifoREn, mValid, mData, mFirst, mLast
    );
endinterface

// File: rtl/word_prefetch_buf.sv
// DEPTH x DATA_W circular word buffer: push at the tail, retire the head, expose head and
// occupancy. A clear returns it to empty without touching stored words.
module word_prefetch_buf
    import fifo_byte_unpacker_pkg::*;
#(
    parameter  int DATA_W = FIFO_DATA_W,
    parameter  int DEPTH  = 2,
    localparam int PTR_W  = (DEPTH > 1) ? clog2(DEPTH) : 1,
    localparam int CNT_W  = clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_clear,
    input  logic              i_push,
    input  logic [DATA_W-1:0] i_push_data,
    input  logic              i_pop,
    output logic [DATA_W-1:0] o_head,
    output logic [CNT_W-1:0]  o_count
);
    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [CNT_W-1:0]  r_count;

    // NOTE: storage has no reset; occupancy alone decides which entries are meaningful.
    always_ff @(posedge clk) begin
        if (i_push) begin
            r_mem[r_wr_ptr] <= i_push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n || i_clear) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (i_push) begin
                r_wr_ptr <= (r_wr_ptr == PTR_W'(DEPTH - 1)) ? '0 : r_wr_ptr + PTR_W'(1);
            end
            if (i_pop) begin
                r_rd_ptr <= (r_rd_ptr == PTR_W'(DEPTH - 1)) ? '0 : r_rd_ptr + PTR_W'(1);
            end
            case ({i_push, i_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_head  = r_mem[r_rd_ptr];
    assign o_count = r_count;

    a_no_push_when_full: assert property (@(posedge clk) disable iff (!rst_n)
        !(i_push && (r_count == CNT_W'(DEPTH))));
    a_no_pop_when_empty: assert property (@(posedge clk) disable iff (!rst_n)
        !(i_pop && (r_count == '0)));

endmodule

// File: rtl/fifo_byte_unpacker.sv
// Pops words from an async FIFO read port into a small prefetch buffer and emits them as
// RATIO beats per word over a valid/ready stream, sustaining one beat per clock.
module fifo_byte_unpacker
    import fifo_byte_unpacker_pkg::*;
#(
    parameter int DATA_W    = FIFO_DATA_W,
    parameter int OUT_W     = 8,
    parameter int DEPTH     = 2,
    parameter bit LSB_FIRST = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 flush,
    fifo_byte_unpacker_if.master bus,
    output logic                 busy
);
    localparam int RATIO  = DATA_W / OUT_W;
    localparam int BEAT_W = (RATIO > 1) ? clog2(RATIO) : 1;
    localparam int CNT_W  = clog2(DEPTH + 1);

    logic [BEAT_W-1:0] r_beat_idx;
    logic [BEAT_W-1:0] w_beat_sel;
    logic [DATA_W-1:0] w_head;
    logic [CNT_W-1:0]  w_count;
    logic              w_has_word;
    logic              w_valid;
    logic              w_pop_fifo;
    logic              w_last_beat;
    logic              w_xfer;
    logic              w_retire;

    assign w_has_word  = (w_count != '0);
    assign w_valid     = rst_n & w_has_word;
    assign w_pop_fifo  = rst_n & ~flush & ~bus.fifoEmpty & (w_count < CNT_W'(DEPTH));
    assign w_last_beat = (r_beat_idx == BEAT_W'(RATIO - 1));
    // Beats offered during a flush are discarded, so they never advance the word.
    assign w_xfer      = w_valid & bus.mReady & ~flush;
    assign w_retire    = w_xfer & w_last_beat;

    word_prefetch_buf #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_buf (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_clear     (flush),
        .i_push      (w_pop_fifo),
        .i_push_data (bus.fifoData),
        .i_pop       (w_retire),
        .o_head      (w_head),
        .o_count     (w_count)
    );

    // NOTE: state updates use non-blocking assignments so every flop sees pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            r_beat_idx <= '0;
        end else if (w_xfer) begin
            r_beat_idx <= w_last_beat ? '0 : r_beat_idx + BEAT_W'(1);
        end
    end

    assign w_beat_sel  = LSB_FIRST ? r_beat_idx : BEAT_W'(RATIO - 1) - r_beat_idx;

    assign bus.fifoREn = w_pop_fifo;
    assign bus.mValid  = w_valid;
    assign bus.mData   = w_valid ? w_head[int'(w_beat_sel)*OUT_W +: OUT_W] : '0;
    assign bus.mFirst  = w_valid & (r_beat_idx == '0);
    assign bus.mLast   = w_valid & w_last_beat;
    assign busy        = rst_n & (w_has_word | w_pop_fifo);

endmodule
